// File: rtl/disp_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package disp_pkg;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

    // Scan ticks per digit slot; the last tick of every slot is always dark.
    localparam int SLOT_TICKS = 8;

    // Round-robin choice between the two requesters.
    // Returns the index to grant. The caller only uses it when req != 0.
    function automatic logic arb_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divides clk down to one scan tick every CLK_DIV cycles while enabled.
module scan_prescaler #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Count 0..CLK_DIV-1 while enabled; held at zero whenever disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == CNT_MAX);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display,
// shared round-robin between two frame requesters.
//
// Handshake: requester i holds req[i] high while it wants frames shown. The
// controller answers with a one-hot gnt that stays fixed for a whole frame;
// frame_done[i] pulses for one cycle as requester i's frame ends. Dropping req
// mid-frame never aborts the frame in progress; it only stops the next one.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int DIGITS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [4*DIGITS-1:0] src0_data,
    input  logic [4*DIGITS-1:0] src1_data,
    input  logic [2:0]          bright,
    output logic [1:0]          gnt,
    output logic [1:0]          frame_done,
    output logic [DIGITS-1:0]   an,
    output logic [3:0]          dnum
);

    localparam int            DW     = $clog2(DIGITS);
    localparam int            TW     = $clog2(SLOT_TICKS);
    localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(SLOT_TICKS - 1);

    scan_state_t         state, state_n;
    logic [1:0]          gnt_n, fd_n;
    logic                last, last_n, pick;
    logic [TW-1:0]       t, t_n;
    logic [DW-1:0]       digit, digit_n;
    logic [2:0]          bl, bl_n;
    logic [DIGITS-1:0]   an_n;
    logic [3:0]          dnum_n;
    logic                tick;

    scan_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state == S_SCAN),
        .tick (tick)
    );

    // Next-state, arbitration, slot/digit sequencing and the next output values.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        last_n  = last;
        t_n     = t;
        digit_n = digit;
        bl_n    = bl;
        fd_n    = '0;
        an_n    = '0;
        dnum_n  = '0;
        pick    = arb_pick(req, last);

        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_n = S_SCAN;
                    gnt_n   = pick ? 2'b10 : 2'b01;
                    last_n  = pick;
                    t_n     = '0;
                    digit_n = '0;
                    bl_n    = bright;
                end
            end
            S_SCAN: begin
                // Lit for the first bl ticks of the slot; dnum is blanked with the anode.
                if (t < TW'(bl)) begin
                    an_n   = DIGITS'(1) << digit;
                    dnum_n = gnt[1] ? src1_data[{digit, 2'b00} +: 4]
                                    : src0_data[{digit, 2'b00} +: 4];
                end
                if (tick) begin
                    if (t == T_LAST) begin
                        t_n  = '0;
                        bl_n = bright;
                        if (digit == D_LAST) begin
                            // Frame boundary: report the finished owner and re-arbitrate.
                            digit_n = '0;
                            fd_n    = gnt;
                            if (req == 2'b00) begin
                                state_n = S_IDLE;
                                gnt_n   = 2'b00;
                            end else begin
                                gnt_n  = pick ? 2'b10 : 2'b01;
                                last_n = pick;
                            end
                        end else begin
                            digit_n = digit + 1'b1;
                        end
                    end else begin
                        t_n = t + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and leaves last=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt        <= '0;
            last       <= 1'b1;
            t          <= '0;
            digit      <= '0;
            bl         <= '0;
            frame_done <= '0;
            an         <= '0;
            dnum       <= '0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            last       <= last_n;
            t          <= t_n;
            digit      <= digit_n;
            bl         <= bl_n;
            frame_done <= fd_n;
            an         <= an_n;
            dnum       <= dnum_n;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (CLK_DIV=4, DIGITS=4).
module tb_display_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int DIGITS    = 4;
    localparam int SLOT      = 8;
    localparam int SLOT_CLKS = SLOT * CLK_DIV;
    localparam int FRAME     = DIGITS * SLOT_CLKS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] src0_data = 16'h0;
    logic [15:0] src1_data = 16'h0;
    logic [2:0]  bright = 3'd0;
    logic [1:0]  gnt, frame_done;
    logic [3:0]  an, dnum;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one cycle counter per frame, times derived arithmetically.
    logic        m_active = 1'b0;
    logic        m_pick   = 1'b0;
    logic        m_last   = 1'b1;
    int          m_k      = 0;
    logic [2:0]  m_bl     = 3'd0;
    logic [1:0]  exp_gnt  = 2'b00;
    logic [1:0]  exp_fd   = 2'b00;
    logic [3:0]  exp_an   = 4'b0;
    logic [3:0]  exp_dnum = 4'b0;

    // Per-frame measurement results.
    logic [1:0]  r_gnt, r_fd;
    logic [15:0] r_nibs;
    int          r_lit[4];
    int          r_len;

    typedef struct {
        logic [1:0]  req;
        logic [2:0]  bright;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [1:0]  e_gnt;
        logic [15:0] e_nibs;
        int          e_lit;
    } vec_t;

    vec_t vt[5];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .CLK_DIV (CLK_DIV),
        .DIGITS  (DIGITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .src0_data  (src0_data),
        .src1_data  (src1_data),
        .bright     (bright),
        .gnt        (gnt),
        .frame_done (frame_done),
        .an         (an),
        .dnum       (dnum)
    );

    function automatic logic choose(input logic [1:0] r, input logic l);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return !l;
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] d, input int s);
        logic [15:0] x;
        x = d >> (4 * s);
        return x[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Advance the model with the inputs the DUT will sample at the next posedge.
    task automatic model_advance();
        int tk, slot, tt;
        if (rst) begin
            m_active = 1'b0; m_pick = 1'b0; m_last = 1'b1; m_k = 0; m_bl = 3'd0;
            exp_gnt = 2'b00; exp_fd = 2'b00; exp_an = 4'b0; exp_dnum = 4'b0;
            return;
        end
        exp_an = 4'b0; exp_dnum = 4'b0; exp_fd = 2'b00;
        if (m_active) begin
            tk = m_k / CLK_DIV; slot = tk / SLOT; tt = tk % SLOT;
            if (tt < int'(m_bl)) begin
                exp_an   = 4'(1 << slot);
                exp_dnum = nibble(m_pick ? src1_data : src0_data, slot);
            end
            if (m_k == FRAME - 1) begin
                exp_fd = m_pick ? 2'b10 : 2'b01;
                m_k = 0; m_bl = bright;
                if (req == 2'b00) m_active = 1'b0;
                else begin m_pick = choose(req, m_last); m_last = m_pick; end
            end else begin
                m_k++;
                if (m_k % SLOT_CLKS == 0) m_bl = bright;
            end
        end else if (req != 2'b00) begin
            m_active = 1'b1; m_pick = choose(req, m_last); m_last = m_pick;
            m_k = 0; m_bl = bright;
        end
        exp_gnt = m_active ? (m_pick ? 2'b10 : 2'b01) : 2'b00;
    endtask

    task automatic step();
        model_advance();
        @(negedge clk);
        check("cycle", {20'h0, gnt, frame_done, an, dnum},
                       {20'h0, exp_gnt, exp_fd, exp_an, exp_dnum});
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00;
        repeat (3) begin
            step();
            check("reset_outputs", {20'h0, gnt, frame_done, an, dnum}, 32'h0);
        end
        rst = 1'b0;
    endtask

    // Step until frame_done, recording lit time and nibble per digit.
    task automatic measure_frame(input int change_at, input logic [1:0] new_req,
                                 input logic [2:0] new_bright);
        bit done = 0;
        r_gnt = 2'b00; r_fd = 2'b00; r_nibs = 16'h0; r_len = 0;
        for (int d = 0; d < 4; d++) r_lit[d] = 0;
        for (int i = 1; i <= 400 && !done; i++) begin
            if (i == change_at) begin req = new_req; bright = new_bright; end
            step();
            if (i == 1) r_gnt = gnt;
            for (int d = 0; d < 4; d++) begin
                if (an == 4'(1 << d)) begin
                    r_lit[d]++;
                    r_nibs[d*4 +: 4] = dnum;
                end
            end
            if (frame_done != 2'b00) begin r_fd = frame_done; r_len = i; done = 1; end
        end
        if (!done) check("frame_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vt[0] = '{2'b01, 3'd7, 16'h4321, 16'hABCD, 2'b01, 16'h4321, 28};
        vt[1] = '{2'b10, 3'd7, 16'h4321, 16'hABCD, 2'b10, 16'hABCD, 28};
        vt[2] = '{2'b11, 3'd3, 16'h1234, 16'h5678, 2'b01, 16'h1234, 12};
        vt[3] = '{2'b01, 3'd0, 16'h9999, 16'h0000, 2'b01, 16'h0000, 0};
        vt[4] = '{2'b10, 3'd1, 16'h0000, 16'hF0E9, 2'b10, 16'hF0E9, 4};

        // Single frames from a fresh reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            req = vt[v].req; bright = vt[v].bright;
            src0_data = vt[v].s0; src1_data = vt[v].s1;
            measure_frame(-1, 2'b00, 3'd0);
            check("vec_gnt",  32'(r_gnt), 32'(vt[v].e_gnt));
            check("vec_fd",   32'(r_fd),  32'(vt[v].e_gnt));
            check("vec_nibs", 32'(r_nibs), 32'(vt[v].e_nibs));
            for (int d = 0; d < 4; d++) check("vec_lit", 32'(r_lit[d]), 32'(vt[v].e_lit));
            check("vec_len",  32'(r_len), 32'(FRAME + 1));
        end

        // Both requesting: grants alternate starting with source 0.
        do_reset();
        req = 2'b11; bright = 3'd7; src0_data = 16'h4321; src1_data = 16'hABCD;
        for (int f = 0; f < 3; f++) begin
            measure_frame(-1, 2'b00, 3'd0);
            check("alt_gnt", 32'(r_gnt), (f % 2 == 0) ? 32'h1 : 32'h2);
            check("alt_fd",  32'(r_fd),  (f % 2 == 0) ? 32'h1 : 32'h2);
            check("alt_len", 32'(r_len), (f == 0) ? 32'(FRAME + 1) : 32'(FRAME));
        end

        // Mid-slot brightness change applies from the next slot.
        do_reset();
        req = 2'b01; bright = 3'd2; src0_data = 16'h8765;
        measure_frame(10, 2'b01, 3'd6);
        check("bright_slot0", 32'(r_lit[0]), 32'd8);
        check("bright_slot1", 32'(r_lit[1]), 32'd24);

        // Dropping req mid-frame still completes the frame, then idles.
        do_reset();
        req = 2'b01; bright = 3'd7; src0_data = 16'h2468;
        measure_frame(40, 2'b00, 3'd7);
        check("drop_fd",   32'(r_fd), 32'h1);
        check("drop_lit3", 32'(r_lit[3]), 32'd28);
        check("drop_idle", {28'h0, gnt, frame_done & 2'b00}, 32'h0);
        repeat (5) step();
        check("drop_idle_later", {24'h0, gnt, 2'b00, an}, 32'h0);

        // Reset at digit 2 aborts silently; next frame starts at digit 0.
        do_reset();
        req = 2'b01; bright = 3'd7; src0_data = 16'h1357; src1_data = 16'h9BDF;
        repeat (70) step();
        rst = 1'b1;
        step();
        check("abort_outputs", {20'h0, gnt, frame_done, an, dnum}, 32'h0);
        rst = 1'b0; req = 2'b10;
        measure_frame(-1, 2'b00, 3'd0);
        check("abort_gnt",  32'(r_gnt), 32'h2);
        check("abort_fd",   32'(r_fd),  32'h2);
        check("abort_d0",   32'(r_lit[0]), 32'd28);
        check("abort_len",  32'(r_len), 32'(FRAME + 1));
        check("abort_nibs", 32'(r_nibs), 32'h9BDF);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) bright = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) src0_data = 16'($urandom);
            if ($urandom_range(0, 99) == 0) src1_data = 16'($urandom);
            rst = ($urandom_range(0, 799) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
